ctrl_seq: RTL

CTRL_SEQ -- requirements
Module: ctrl_seq

---
 rtl/ctrl_seq.sv | 147 ++++++++++++++
 1 files changed

// File: rtl/ctrl_seq.sv
// Multi-cycle control sequencer: decodes the current instruction into datapath
// strobes, stretches loads/stores over MEM_LAT wait cycles and counts busy cycles.
module ctrl_seq #(
  parameter int IW      = 9,
  parameter int OPW     = 4,
  parameter int MEM_LAT = 1,
  parameter int CW      = 16
) (
  input  logic           Clk,
  input  logic           Reset,
  input  logic           Start,
  input  logic [IW-1:0]  Instruction,
  output logic           PCEn,
  output logic           BranchEn,
  output logic           RegWrEn,
  output logic           MemWrEn,
  output logic           MemRdEn,
  output logic           ALUEn,
  output logic           LUTdm,
  output logic [OPW-1:0] AluOp,
  output logic           Busy,
  output logic           Ack,
  output logic [CW-1:0]  CycleCnt
);

  typedef enum logic [1:0] {IDLE, RUN, MEMWAIT, DONE} state_t;

  localparam bit         HAS_LAT   = (MEM_LAT > 0);
  localparam logic [3:0] WAIT_INIT = (MEM_LAT > 0) ? 4'(MEM_LAT - 1) : 4'd0;

  state_t         state;
  logic [3:0]     wait_cnt;
  logic [OPW-1:0] op_lat;

  logic [OPW-1:0] opcode;
  logic           halt;
  logic           cur_mem;
  logic [5:0]     dec_cur;
  logic [5:0]     dec_lat;

  // Strobe bundle order: {BranchEn, RegWrEn, MemWrEn, MemRdEn, ALUEn, LUTdm}
  function automatic logic [5:0] decode(input logic [OPW-1:0] op);
    logic [5:0] d;
    d = 6'b000000;
    case (op)
      OPW'(0):  d = 6'b010100;
      OPW'(1):  d = 6'b010101;
      OPW'(2):  d = 6'b001001;
      OPW'(3):  d = 6'b001000;
      OPW'(4), OPW'(5), OPW'(6), OPW'(7),
      OPW'(9), OPW'(10), OPW'(14):
                d = 6'b010010;
      OPW'(8):  d = 6'b010000;
      OPW'(11), OPW'(13):
                d = 6'b100000;
      default:  d = 6'b000000;
    endcase
    return d;
  endfunction

  function automatic logic is_mem(input logic [OPW-1:0] op);
    return (op == OPW'(0)) || (op == OPW'(1)) || (op == OPW'(2)) || (op == OPW'(3));
  endfunction

  function automatic logic is_load(input logic [OPW-1:0] op);
    return (op == OPW'(0)) || (op == OPW'(1));
  endfunction

  assign opcode  = Instruction[IW-1:IW-OPW];
  assign halt    = &Instruction;
  assign cur_mem = HAS_LAT && is_mem(opcode);
  assign dec_cur = decode(opcode);
  assign dec_lat = decode(op_lat);

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state    <= IDLE;
      wait_cnt <= '0;
      op_lat   <= '0;
      CycleCnt <= '0;
      Busy     <= 1'b0;
      Ack      <= 1'b0;
    end else begin
      if ((state == RUN || state == MEMWAIT) && !(&CycleCnt))
        CycleCnt <= CycleCnt + CW'(1);
      case (state)
        IDLE, DONE: begin
          if (Start) begin
            state    <= RUN;
            CycleCnt <= '0;
            Busy     <= 1'b1;
            Ack      <= 1'b0;
          end
        end
        RUN: begin
          if (halt) begin
            state <= DONE;
            Busy  <= 1'b0;
            Ack   <= 1'b1;
          end else if (cur_mem) begin
            state    <= MEMWAIT;
            wait_cnt <= WAIT_INIT;
            op_lat   <= opcode;
          end
        end
        MEMWAIT: begin
          if (wait_cnt == 4'd0) state <= RUN;
          else                  wait_cnt <= wait_cnt - 4'd1;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Strobes follow the live instruction in RUN, the latched opcode in MEMWAIT.
  always_comb begin
    PCEn     = 1'b0;
    BranchEn = 1'b0;
    RegWrEn  = 1'b0;
    MemWrEn  = 1'b0;
    MemRdEn  = 1'b0;
    ALUEn    = 1'b0;
    LUTdm    = 1'b0;
    AluOp    = '0;
    case (state)
      RUN: begin
        AluOp = opcode;
        if (!halt) begin
          {BranchEn, RegWrEn, MemWrEn, MemRdEn, ALUEn, LUTdm} = dec_cur;
          if (cur_mem) RegWrEn = 1'b0;
          else         PCEn    = 1'b1;
        end
      end
      MEMWAIT: begin
        AluOp = op_lat;
        if (is_load(op_lat)) begin
          MemRdEn = 1'b1;
          LUTdm   = dec_lat[0];
          RegWrEn = (wait_cnt == 4'd0);
        end
        PCEn = (wait_cnt == 4'd0);
      end
      default: ;
    endcase
  end

endmodule
